// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C target state type, R/nW constants and bit-order helper
package i2c_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK,
    S_REG_PTR,
    S_WDATA,
    S_RDATA,
    S_WAIT_STOP
  } i2c_tgt_state_t;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ = 1'b1;
  function automatic logic [2:0] bit_index(input logic [2:0] bit_cnt, input logic lsb_first);
    return lsb_first ? bit_cnt : 3'd7 - bit_cnt;
  endfunction
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes raw SCL/SDA and flags SCL edges plus START/STOP conditions
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end
  assign sda_o = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C responder exposing a byte register file over the bus and a local port
module i2c_target import i2c_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = 7'h1D,
  parameter int NUM_REGS = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int PTR_W = $clog2(NUM_REGS)
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  input  logic loc_we,
  input  logic [PTR_W-1:0] loc_addr,
  input  logic [7:0] loc_wdata,
  output logic [7:0] loc_rdata,
  output logic bus_wr,
  output logic [PTR_W-1:0] bus_wr_addr,
  output logic [7:0] bus_wr_data,
  output logic busy
);
  logic sda, scl_rise, scl_fall, start, stop, active, load_rd;
  i2c_tgt_state_t state_q;
  logic [3:0] bit_cnt_q;
  logic [2:0] bit_idx;
  logic [7:0] shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic rw_q;
  logic [7:0] regs_q [NUM_REGS];
  i2c_bus_sync u_sync (
    .clk(clk),
    .rst(rst),
    .scl_i(scl_i),
    .sda_i(sda_i),
    .sda_o(sda),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o(start),
    .stop_o(stop)
  );
  assign active = state_q != S_IDLE && state_q != S_WAIT_STOP;
  assign load_rd = state_q == S_RDATA || (state_q == S_ACK && rw_q == I2C_RW_READ);
  assign ptr_d = ptr_q == PTR_W'(NUM_REGS - 1) ? '0 : ptr_q + 1'b1;
  assign loc_rdata = regs_q[loc_addr];
  always_comb begin
    bit_idx = bit_index(bit_cnt_q[2:0], LSB_FIRST);
    shift_d = shift_q;
    shift_d[bit_idx] = sda;
  end
  always_ff @(posedge clk) begin
    bus_wr <= 1'b0;
    if (loc_we) regs_q[loc_addr] <= loc_wdata;
    if (rst) begin
      state_q <= S_IDLE;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      bus_wr_addr <= '0;
      bus_wr_data <= '0;
      ptr_q <= '0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      rw_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (stop) begin
      state_q <= S_IDLE;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      bit_cnt_q <= '0;
    end else if (start) begin
      state_q <= S_ADDR;
      sda_oe <= 1'b0;
      bit_cnt_q <= '0;
    end else if (active && scl_rise) begin
      bit_cnt_q <= bit_cnt_q + 4'd1;
      if (bit_cnt_q < 4'd8 && state_q != S_RDATA) shift_q <= shift_d;
      if (bit_cnt_q == 4'd7 && state_q == S_ADDR) begin
        state_q <= shift_d[7:1] == DEV_ADDR ? S_ACK : S_WAIT_STOP;
        busy <= shift_d[7:1] == DEV_ADDR;
        rw_q <= shift_d[0];
      end
      if (bit_cnt_q == 4'd7 && state_q == S_REG_PTR) begin
        if (int'(shift_d) < NUM_REGS) ptr_q <= shift_d[PTR_W-1:0];
        else begin
          state_q <= S_WAIT_STOP;
          busy <= 1'b0;
        end
      end
      if (bit_cnt_q == 4'd7 && state_q == S_WDATA) begin
        regs_q[ptr_q] <= shift_d;
        bus_wr <= 1'b1;
        bus_wr_addr <= ptr_q;
        bus_wr_data <= shift_d;
        ptr_q <= ptr_d;
      end
      if (bit_cnt_q == 4'd8 && state_q == S_RDATA) begin
        if (sda) begin
          state_q <= S_WAIT_STOP;
          busy <= 1'b0;
        end else ptr_q <= ptr_d;
      end
    end else if (active && scl_fall) begin
      if (bit_cnt_q == 4'd9) begin
        bit_cnt_q <= '0;
        state_q <= state_q == S_ACK ? (rw_q == I2C_RW_WRITE ? S_REG_PTR : S_RDATA) :
                   state_q == S_REG_PTR ? S_WDATA : state_q;
        sda_oe <= load_rd & ~regs_q[ptr_q][bit_index(3'd0, LSB_FIRST)];
        if (load_rd) shift_q <= regs_q[ptr_q];
      end else sda_oe <= bit_cnt_q == 4'd8 ? state_q != S_RDATA : state_q == S_RDATA && ~shift_q[bit_idx];
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: randomized bus transactions checked against a register-file model of the target
module tb_i2c_target;
  localparam logic [6:0] DEV = 7'h1D;
  localparam int N = 8;
  localparam int Q = 4;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, loc_we = 1'b0;
  logic [2:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  logic [7:0] loc_rdata, bus_wr_data;
  logic [2:0] bus_wr_addr;
  logic sda_oe, bus_wr, busy, sda_bus;
  int checks = 0, errors = 0;
  logic [7:0] m_regs [N];
  int m_ptr;
  logic [7:0] tx_q[$];
  logic [10:0] wr_log[$], exp_log[$];
  bit oe_seen, busy_seen;
  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_target dut (
    .clk(clk),
    .rst(rst),
    .scl_i(scl_m),
    .sda_i(sda_bus),
    .sda_oe(sda_oe),
    .loc_we(loc_we),
    .loc_addr(loc_addr),
    .loc_wdata(loc_wdata),
    .loc_rdata(loc_rdata),
    .bus_wr(bus_wr),
    .bus_wr_addr(bus_wr_addr),
    .bus_wr_data(bus_wr_data),
    .busy(busy)
  );
  always @(negedge clk) begin
    if (bus_wr) wr_log.push_back({bus_wr_addr, bus_wr_data});
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clock_bit(input logic b, output logic r);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    r = sda_bus;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 0; i < 8; i++) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    ack = ~r;
  endtask
  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic r;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, r);
      b[i] = r;
    end
    clock_bit(~ack, r);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask
  task automatic loc_write(input int a, input logic [7:0] d);
    loc_we = 1'b1;
    loc_addr = 3'(a);
    loc_wdata = d;
    tick(1);
    loc_we = 1'b0;
    m_regs[a] = d;
  endtask
  task automatic check_regs(input string tag);
    for (int i = 0; i < N; i++) begin
      loc_addr = 3'(i);
      #1;
      check(tag, loc_rdata, m_regs[i]);
      tick(1);
    end
  endtask
  task automatic bus_write(input logic [7:0] p, input bit do_stop);
    logic a;
    bit ok;
    wr_log.delete();
    exp_log.delete();
    i2c_start();
    send_byte({DEV, 1'b0}, a);
    check("wr addr ack", a, 1);
    check("wr busy", busy, 1);
    send_byte(p, a);
    ok = p < N;
    check("wr ptr ack", a, ok);
    if (ok) m_ptr = p;
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], a);
      check("wr data ack", a, ok);
      if (ok) begin
        exp_log.push_back({3'(m_ptr), tx_q[i]});
        m_regs[m_ptr] = tx_q[i];
        m_ptr = (m_ptr + 1) % N;
      end
    end
    if (do_stop) begin
      i2c_stop();
      tick(Q);
      check("wr idle busy", busy, 0);
    end
    check("wr pulse count", wr_log.size(), exp_log.size());
    foreach (exp_log[i]) if (i < wr_log.size()) check("wr pulse", wr_log[i], exp_log[i]);
  endtask
  task automatic bus_read(input int n);
    logic a;
    logic [7:0] b;
    i2c_start();
    send_byte({DEV, 1'b1}, a);
    check("rd addr ack", a, 1);
    check("rd busy", busy, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, b);
      check("rd data", b, m_regs[m_ptr]);
      if (i != n - 1) m_ptr = (m_ptr + 1) % N;
    end
    check("rd release after nack", sda_oe, 0);
    i2c_stop();
    tick(Q);
  endtask
  initial begin
    logic a;
    int p, n;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_ptr = 0;
    tick(4);
    rst = 1'b0;
    tick(2);
    check("reset sda_oe", sda_oe, 0);
    check("reset busy", busy, 0);
    check("reset bus_wr", bus_wr, 0);
    check_regs("reset regs");
    tx_q = {8'hA5, 8'h3C};
    bus_write(8'd2, 1'b1);
    loc_addr = 3'd3;
    #1;
    check("loc rdata 3", loc_rdata, 8'h3C);
    tick(1);
    loc_write(3, 8'h5A);
    loc_write(4, 8'hC3);
    tx_q.delete();
    bus_write(8'd3, 1'b1);
    bus_read(2);
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    wr_log.delete();
    i2c_start();
    send_byte({7'h1E, 1'b0}, a);
    check("mismatch ack", a, 0);
    send_byte(8'h02, a);
    send_byte(8'hFF, a);
    i2c_stop();
    tick(Q);
    check("mismatch sda_oe", oe_seen, 0);
    check("mismatch busy", busy_seen, 0);
    check("mismatch writes", wr_log.size(), 0);
    tx_q = {8'h11, 8'h22};
    bus_write(8'd7, 1'b1);
    check_regs("wrap regs");
    tx_q = {8'(($urandom_range(0, 255)))};
    bus_write(8'h09, 1'b1);
    check_regs("bad ptr regs");
    tx_q.delete();
    bus_write(8'd5, 1'b0);
    bus_read(2);
    for (int k = 0; k < 6; k++) begin
      p = int'($urandom_range(0, 11));
      n = int'($urandom_range(1, 4));
      tx_q.delete();
      for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom_range(0, 255)));
      bus_write(8'(p), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        tx_q.delete();
        bus_write(8'($urandom_range(0, 7)), 1'b1);
      end
      bus_read(int'($urandom_range(1, 4)));
    end
    check_regs("random regs");
    loc_write(1, 8'h00);
    tx_q.delete();
    bus_write(8'd1, 1'b1);
    i2c_start();
    send_byte({DEV, 1'b1}, a);
    check("pre-reset addr ack", a, 1);
    check("pre-reset driving 0", sda_oe, 1);
    rst = 1'b1;
    tick(1);
    check("reset mid-read sda_oe", sda_oe, 0);
    check("reset mid-read busy", busy, 0);
    rst = 1'b0;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_ptr = 0;
    i2c_stop();
    tick(Q);
    tx_q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    bus_write(8'd6, 1'b1);
    tx_q.delete();
    bus_write(8'd6, 1'b1);
    bus_read(2);
    check_regs("post-reset regs");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
